crc_pause_stack: RTL and testbench
==================================

Name: crc_pause_stack

Overview:
- Context LIFO that stores and restores the fingerprint CRC state of a task when the pause/unpause controller preempts it or resumes it.
- Consumes the controller's one-cycle strobes: store, load and setfsm/popstack.
- Returns three values to the controller's unpause loop: stack-not-empty, the top-of-stack task key, and the restored CRC context for the CRC datapath.
- Detects overflow and underflow with sticky flags, because nesting deeper than the stack is a reportable system fault.

Parameters:
- KEY_WIDTH, 4: width of the task key (index into the controller's pause task register).
- CRC_WIDTH, 32: width of the saved CRC accumulator.
- CNT_WIDTH, 16: width of the saved block/instruction counter.
- PTR_WIDTH, 3: stack depth is 2**PTR_WIDTH entries (default 8).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- push  in  1  pause_store strobe: push the current context
- load  in  1  unpause_load strobe: drive the top entry onto the restore outputs
- pop  in  1  unpause_setfsm_popstack strobe: discard the top entry
- clear_flags  in  1  clears overflow and underflow
- push_key  in  KEY_WIDTH  key of the task being paused
- push_crc  in  CRC_WIDTH  CRC accumulator of the task being paused
- push_count  in  CNT_WIDTH  counter of the task being paused
- restore_key  out  KEY_WIDTH  restored key, registered
- restore_crc  out  CRC_WIDTH  restored CRC, registered
- restore_count  out  CNT_WIDTH  restored counter, registered
- restore_valid  out  1  one-cycle pulse; restore_* are valid while it is high
- empty_n  out  1  high when depth != 0
- full  out  1  high when depth == 2**PTR_WIDTH
- tos_key  out  KEY_WIDTH  key of the top entry; 0 when empty
- depth  out  PTR_WIDTH+1  number of valid entries
- overflow  out  1  sticky: a push was attempted while full
- underflow  out  1  sticky: a load or pop was attempted while empty

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0: depth, restore_*, restore_valid, overflow, underflow. Therefore empty_n=0 and full=0. Entry storage is not reset.
- Storage: 2**PTR_WIDTH entries of {key, crc, count}. The write pointer equals depth; the top entry is at index depth-1.
- Push (push=1, pop=0):
  - If not full, write the push_* values at index depth, then depth+1.
  - If full, nothing is written, depth is unchanged, and overflow is set.
- Pop (pop=1, push=0):
  - If not empty, depth-1. Entry contents are not cleared.
  - If empty, depth stays 0 and underflow is set.
- Simultaneous push and pop:
  - Non-empty: replace the top entry (write at depth-1); depth unchanged; no flags change.
  - Empty: treated as a push only; underflow is not set.
- Load:
  - Non-empty: on the load edge, register the top entry into restore_* and assert restore_valid for exactly the following cycle.
  - Empty: restore_* hold their values, restore_valid stays 0, and underflow is set.
- Load with pop or push in the same cycle: load samples the top entry as it was before that cycle's push or pop.
- Restore outputs hold their value until the next successful load. restore_valid is 0 in every cycle that does not follow a successful load.
- tos_key, empty_n, full and depth are combinational from registered depth and storage. They reflect a push or pop on the cycle after the strobe. The controller's unpause loop samples them in its init state.
- Sticky flags:
  - clear_flags clears overflow and underflow on the next edge.
  - A fault in the same cycle as clear_flags wins: the flag is set.
- Strobes are single-cycle from the controller. Back-to-back strobes in consecutive cycles are fully supported; no internal busy state is required.
- Reset mid-sequence, e.g. between load and pop: depth returns to 0 and a later pop sets underflow.
- No wrap-around: depth saturates at 0 and 2**PTR_WIDTH. The pointer never wraps.

Test Plan:
- Reset, then push key=3/crc=0xDEADBEEF/count=0x0010 -> next cycle depth=1, empty_n=1, tos_key=3; load -> next cycle restore_valid=1, restore_crc=0xDEADBEEF, restore_count=0x0010; pop -> depth=0, empty_n=0, tos_key=0.
- Push keys 1..8 with depth 8 -> full=1, tos_key=8; push key 9 -> overflow=1, depth=8, tos_key=8; pop 8 times -> tos_key follows 7,6,...,1, then 0; clear_flags -> overflow=0.
- Pop and load on an empty stack -> underflow=1, restore_valid stays 0, depth=0; clear_flags in the same cycle as a further pop -> underflow stays 1.
- Depth=2 (keys 5, 6), push key 7 and pop in the same cycle -> depth=2, tos_key=7; with depth=0, push key 2 and pop in the same cycle -> depth=1, underflow=0.
- Full pause/unpause strobe sequence (store, then load, then setfsm one cycle apart) at depth=1, plus load and push key 4 in the same cycle -> restored key equals the pre-push top; depth=2 afterwards, tos_key=4.
- Push 3 entries, assert rst_n low mid-cycle asynchronously -> depth, flags and restore_valid are 0 immediately; after release, pop -> underflow=1.

Source files
------------

// File: rtl/crc_pause_stack.sv
// Context LIFO for the pause/unpause controller: saves {key, crc, count} per
// preempted task, restores the top entry on load, flags overflow/underflow.
module crc_pause_stack #(
  parameter int unsigned KEY_WIDTH = 4,
  parameter int unsigned CRC_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned PTR_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 load,
  input  logic                 pop,
  input  logic                 clear_flags,
  input  logic [KEY_WIDTH-1:0] push_key,
  input  logic [CRC_WIDTH-1:0] push_crc,
  input  logic [CNT_WIDTH-1:0] push_count,
  output logic [KEY_WIDTH-1:0] restore_key,
  output logic [CRC_WIDTH-1:0] restore_crc,
  output logic [CNT_WIDTH-1:0] restore_count,
  output logic                 restore_valid,
  output logic                 empty_n,
  output logic                 full,
  output logic [KEY_WIDTH-1:0] tos_key,
  output logic [PTR_WIDTH:0]   depth,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int unsigned ENTRIES = 2 ** PTR_WIDTH;
  localparam logic [PTR_WIDTH:0] DEPTH_MAX = (PTR_WIDTH + 1)'(ENTRIES);
  localparam logic [PTR_WIDTH:0] ONE       = (PTR_WIDTH + 1)'(1);

  logic [KEY_WIDTH-1:0] mem_key   [ENTRIES];
  logic [CRC_WIDTH-1:0] mem_crc   [ENTRIES];
  logic [CNT_WIDTH-1:0] mem_count [ENTRIES];

  logic                 is_empty;
  logic                 is_full;
  logic [PTR_WIDTH:0]   depth_m1;
  logic [PTR_WIDTH-1:0] top_idx;
  logic [PTR_WIDTH-1:0] wr_idx;
  logic                 wr_en;
  logic                 replace_top;
  logic [PTR_WIDTH:0]   depth_next;
  logic                 ovf_event;
  logic                 unf_event;
  logic                 load_ok;

  always_comb begin
    is_empty = (depth == '0);
    is_full  = (depth == DEPTH_MAX);
    depth_m1 = depth - ONE;
    top_idx  = depth_m1[PTR_WIDTH-1:0];
  end

  // Push+pop on a non-empty stack overwrites the top in place; on an empty
  // stack it degenerates to a plain push.
  always_comb begin
    replace_top = push & pop & ~is_empty;
    wr_en       = push & (replace_top | ~is_full);
    wr_idx      = replace_top ? top_idx : depth[PTR_WIDTH-1:0];
    depth_next  = depth;
    if (push && !replace_top && !is_full) begin
      depth_next = depth + ONE;
    end else if (pop && !push && !is_empty) begin
      depth_next = depth - ONE;
    end
    ovf_event = push & ~pop & is_full;
    unf_event = ((pop & ~push) | load) & is_empty;
    load_ok   = load & ~is_empty;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_key[wr_idx]   <= push_key;
      mem_crc[wr_idx]   <= push_crc;
      mem_count[wr_idx] <= push_count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth         <= '0;
      restore_key   <= '0;
      restore_crc   <= '0;
      restore_count <= '0;
      restore_valid <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      depth         <= depth_next;
      restore_valid <= load_ok;
      if (load_ok) begin
        restore_key   <= mem_key[top_idx];
        restore_crc   <= mem_crc[top_idx];
        restore_count <= mem_count[top_idx];
      end
      if (ovf_event)        overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
      if (unf_event)        underflow <= 1'b1;
      else if (clear_flags) underflow <= 1'b0;
    end
  end

  always_comb begin
    empty_n = ~is_empty;
    full    = is_full;
    tos_key = is_empty ? '0 : mem_key[top_idx];
  end

endmodule

// File: tb/tb_crc_pause_stack.sv
// Directed bench for crc_pause_stack with hand-computed expectations.
module tb_crc_pause_stack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push, load, pop, clear_flags;
  logic [3:0]  push_key;
  logic [31:0] push_crc;
  logic [15:0] push_count;
  logic [3:0]  restore_key;
  logic [31:0] restore_crc;
  logic [15:0] restore_count;
  logic        restore_valid, empty_n, full, overflow, underflow;
  logic [3:0]  tos_key;
  logic [3:0]  depth;

  int checks   = 0;
  int failures = 0;

  crc_pause_stack #(.KEY_WIDTH(4), .CRC_WIDTH(32), .CNT_WIDTH(16), .PTR_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .load(load), .pop(pop),
    .clear_flags(clear_flags), .push_key(push_key), .push_crc(push_crc),
    .push_count(push_count), .restore_key(restore_key), .restore_crc(restore_crc),
    .restore_count(restore_count), .restore_valid(restore_valid), .empty_n(empty_n),
    .full(full), .tos_key(tos_key), .depth(depth), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    push = 1'b0; load = 1'b0; pop = 1'b0; clear_flags = 1'b0;
  endtask

  // Apply the currently driven strobes across one rising edge, then release them.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_push(input logic [3:0] k, input logic [31:0] c, input logic [15:0] n);
    push = 1'b1; push_key = k; push_crc = c; push_count = n;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    push_key = '0; push_crc = '0; push_count = '0;
    #12;
    chk("rst_depth", depth, 0);
    chk("rst_empty_n", empty_n, 0);
    chk("rst_full", full, 0);
    chk("rst_valid", restore_valid, 0);
    chk("rst_flags", {overflow, underflow}, 0);
    chk("rst_restore", {restore_key, restore_crc, restore_count}, 0);
    rst_n = 1'b1;

    // single push / load / pop
    set_push(4'd3, 32'hDEADBEEF, 16'h0010); tick();
    chk("p1_depth", depth, 1);
    chk("p1_empty_n", empty_n, 1);
    chk("p1_tos", tos_key, 3);
    chk("p1_valid_idle", restore_valid, 0);
    load = 1'b1; tick();
    chk("l1_valid", restore_valid, 1);
    chk("l1_key", restore_key, 3);
    chk("l1_crc", restore_crc, 32'hDEADBEEF);
    chk("l1_count", restore_count, 16'h0010);
    pop = 1'b1; tick();
    chk("pop1_depth", depth, 0);
    chk("pop1_empty_n", empty_n, 0);
    chk("pop1_tos", tos_key, 0);
    chk("pop1_valid", restore_valid, 0);
    chk("pop1_hold_crc", restore_crc, 32'hDEADBEEF);

    // fill, overflow, drain
    for (int k = 1; k <= 8; k++) begin
      set_push(4'(k), 32'(k) * 32'h01010101, 16'(k)); tick();
    end
    chk("fill_depth", depth, 8);
    chk("fill_full", full, 1);
    chk("fill_tos", tos_key, 8);
    chk("fill_ovf", overflow, 0);
    set_push(4'd9, 32'h99999999, 16'h0009); tick();
    chk("ovf_flag", overflow, 1);
    chk("ovf_depth", depth, 8);
    chk("ovf_tos", tos_key, 8);
    for (int i = 7; i >= 0; i--) begin
      pop = 1'b1; tick();
      chk($sformatf("drain_tos_%0d", i), tos_key, 4'(i));
      chk($sformatf("drain_depth_%0d", i), depth, 4'(i));
    end
    chk("drain_full", full, 0);
    chk("drain_unf", underflow, 0);
    clear_flags = 1'b1; tick();
    chk("clr_ovf", overflow, 0);

    // underflow cases
    pop = 1'b1; tick();
    chk("unf_pop", underflow, 1);
    chk("unf_pop_depth", depth, 0);
    clear_flags = 1'b1; tick();
    chk("unf_clr", underflow, 0);
    load = 1'b1; tick();
    chk("unf_load", underflow, 1);
    chk("unf_load_valid", restore_valid, 0);
    chk("unf_load_hold", restore_crc, 32'hDEADBEEF);
    chk("unf_load_depth", depth, 0);
    clear_flags = 1'b1; pop = 1'b1; tick();
    chk("unf_clr_vs_fault", underflow, 1);
    clear_flags = 1'b1; tick();
    chk("unf_clr2", underflow, 0);

    // simultaneous push and pop
    set_push(4'd5, 32'h55555555, 16'h0005); tick();
    set_push(4'd6, 32'h66666666, 16'h0006); tick();
    set_push(4'd7, 32'h77777777, 16'h0007); pop = 1'b1; tick();
    chk("pp_depth", depth, 2);
    chk("pp_tos", tos_key, 7);
    chk("pp_flags", {overflow, underflow}, 0);
    pop = 1'b1; tick();
    chk("pp_pop_tos", tos_key, 5);
    pop = 1'b1; tick();
    chk("pp_pop_depth", depth, 0);
    set_push(4'd2, 32'h22222222, 16'h0002); pop = 1'b1; tick();
    chk("pp_empty_depth", depth, 1);
    chk("pp_empty_unf", underflow, 0);
    chk("pp_empty_tos", tos_key, 2);
    pop = 1'b1; tick();

    // store / load / setfsm sequence, then load with push
    set_push(4'hA, 32'h12345678, 16'h0ABC); tick();
    chk("seq_depth", depth, 1);
    load = 1'b1; tick();
    chk("seq_valid", restore_valid, 1);
    chk("seq_key", restore_key, 4'hA);
    chk("seq_crc", restore_crc, 32'h12345678);
    chk("seq_count", restore_count, 16'h0ABC);
    pop = 1'b1; tick();
    chk("seq_valid_drop", restore_valid, 0);
    chk("seq_pop_depth", depth, 0);
    set_push(4'd1, 32'h11111111, 16'h0001); tick();
    load = 1'b1; set_push(4'd4, 32'h44444444, 16'h0004); tick();
    chk("lp_valid", restore_valid, 1);
    chk("lp_key", restore_key, 1);
    chk("lp_crc", restore_crc, 32'h11111111);
    chk("lp_depth", depth, 2);
    chk("lp_tos", tos_key, 4);

    // asynchronous reset mid-sequence
    set_push(4'd8, 32'h88888888, 16'h0008); tick();
    chk("ar_depth", depth, 3);
    load = 1'b1; tick();
    chk("ar_valid_pre", restore_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_depth0", depth, 0);
    chk("ar_valid0", restore_valid, 0);
    chk("ar_flags0", {overflow, underflow}, 0);
    chk("ar_restore0", restore_crc, 0);
    chk("ar_empty_n0", empty_n, 0);
    #3 rst_n = 1'b1;
    pop = 1'b1; tick();
    chk("ar_pop_unf", underflow, 1);
    chk("ar_pop_depth", depth, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
